// File: rtl/skinny_mask_pkg.sv
// Shared constants, types and the reference S-box for the 3-share Skinny-64 S-box driver.
package skinny_mask_pkg;

  localparam int unsigned NUM_SHARES = 3;
  localparam int unsigned FRESH_W    = 24;
  localparam int unsigned SBOX_LAT   = 2;
  localparam int unsigned NIB_W      = 4;
  localparam int unsigned MASK_W     = 8;
  localparam int unsigned RND_W      = 32;
  localparam int unsigned LFSR_W     = 64;

  // Fibonacci LFSR taps, feedback shifted into bit 0
  localparam int unsigned TAP_A = 63;
  localparam int unsigned TAP_B = 62;
  localparam int unsigned TAP_C = 60;
  localparam int unsigned TAP_D = 59;

  localparam logic [LFSR_W-1:0] SEED_DEFAULT = 64'h0123_4567_89AB_CDEF;

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

  // Unmasked Skinny-64 S-box, reference for checking recombined results
  function automatic logic [NIB_W-1:0] skinny_sbox(input logic [NIB_W-1:0] x);
    logic [NIB_W-1:0] y;
    case (x)
      4'h0: y = 4'hC;
      4'h1: y = 4'h6;
      4'h2: y = 4'h9;
      4'h3: y = 4'h0;
      4'h4: y = 4'h1;
      4'h5: y = 4'hA;
      4'h6: y = 4'h2;
      4'h7: y = 4'hB;
      4'h8: y = 4'h3;
      4'h9: y = 4'h8;
      4'hA: y = 4'h5;
      4'hB: y = 4'hD;
      4'hC: y = 4'h4;
      4'hD: y = 4'hE;
      4'hE: y = 4'h7;
      default: y = 4'hF;
    endcase
    return y;
  endfunction

endpackage

// File: rtl/sbox_d2_share_driver_if.sv
// Handshake, seed and share bus between the share driver and its environment.
interface sbox_d2_share_driver_if;
  import skinny_mask_pkg::*;

  logic                in_valid;
  logic                in_ready;
  logic [NIB_W-1:0]    in_data;
  logic                seed_load;
  logic [LFSR_W-1:0]   seed;
  logic [NIB_W-1:0]    X_s0;
  logic [NIB_W-1:0]    X_s1;
  logic [NIB_W-1:0]    X_s2;
  logic [FRESH_W-1:0]  Fresh;
  logic [NIB_W-1:0]    Y_s0;
  logic [NIB_W-1:0]    Y_s1;
  logic [NIB_W-1:0]    Y_s2;
  logic                out_valid;
  logic                out_ready;
  logic [NIB_W-1:0]    out_data;

  // Driver side
  modport master (
    input  in_valid, in_data, seed_load, seed, Y_s0, Y_s1, Y_s2, out_ready,
    output in_ready, X_s0, X_s1, X_s2, Fresh, out_valid, out_data
  );

  // Environment side: producer, consumer and masked S-box
  modport slave (
    output in_valid, in_data, seed_load, seed, Y_s0, Y_s1, Y_s2, out_ready,
    input  in_ready, X_s0, X_s1, X_s2, Fresh, out_valid, out_data
  );

endinterface

// File: rtl/prng_lfsr64_x32.sv
// 64-bit Fibonacci LFSR advanced 32 steps per enabled cycle; rnd is the post-advance low word.
module prng_lfsr64_x32
  import skinny_mask_pkg::*;
#(
  parameter logic [LFSR_W-1:0] SEED = SEED_DEFAULT
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              en,
  input  logic              load,
  input  logic [LFSR_W-1:0] seed,
  output logic [RND_W-1:0]  rnd
);

  logic [LFSR_W-1:0] state;
  logic [LFSR_W-1:0] adv;

  // Unrolled 32-step advance of the current state
  always_comb begin
    adv = state;
    for (int i = 0; i < int'(RND_W); i++) begin
      adv = {adv[LFSR_W-2:0], adv[TAP_A] ^ adv[TAP_B] ^ adv[TAP_C] ^ adv[TAP_D]};
    end
  end

  assign rnd = adv[RND_W-1:0];

  // State register; an all-zero seed would lock the LFSR, so it falls back to SEED
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= SEED;
    end else if (load) begin
      state <= (seed == '0) ? SEED : seed;
    end else if (en) begin
      state <= adv;
    end
  end

endmodule

// File: rtl/sbox_d2_share_driver.sv
// Splits an unmasked nibble into 3 Boolean shares, drives the masked S-box, recombines its output.
module sbox_d2_share_driver
  import skinny_mask_pkg::*;
#(
  parameter int unsigned       SBOX_LATENCY = SBOX_LAT,
  parameter logic [LFSR_W-1:0] SEED         = SEED_DEFAULT
) (
  input  logic                    clk,
  input  logic                    rst,
  sbox_d2_share_driver_if.master  bus
);

  localparam int unsigned CNT_W = (SBOX_LATENCY > 1) ? $clog2(SBOX_LATENCY) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(SBOX_LATENCY - 1);

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_BUSY = 2'd1;
  localparam logic [1:0] ST_DONE = 2'd2;

  logic [1:0]         state, state_n;
  logic [CNT_W-1:0]   cnt, cnt_n;
  logic [NIB_W-1:0]   x_s0, x_s0_n, x_s1, x_s1_n, x_s2, x_s2_n;
  logic [FRESH_W-1:0] fresh, fresh_n;
  logic               out_valid, out_valid_n;
  logic [NIB_W-1:0]   out_data, out_data_n;
  logic               lfsr_en, lfsr_load, accept;
  logic [RND_W-1:0]   rnd;

  prng_lfsr64_x32 #(.SEED(SEED)) u_prng (
    .clk  (clk),
    .rst  (rst),
    .en   (lfsr_en),
    .load (lfsr_load),
    .seed (bus.seed),
    .rnd  (rnd)
  );

  // Next-state, share and result logic
  always_comb begin
    state_n     = state;
    cnt_n       = cnt;
    x_s0_n      = x_s0;
    x_s1_n      = x_s1;
    x_s2_n      = x_s2;
    fresh_n     = fresh;
    out_valid_n = out_valid;
    out_data_n  = out_data;
    lfsr_en     = 1'b0;
    lfsr_load   = 1'b0;
    accept      = 1'b0;

    case (state)
      ST_IDLE: begin
        if (bus.in_valid) begin
          accept = 1'b1;
        end else if (bus.seed_load) begin
          lfsr_load = 1'b1;
        end
      end
      ST_BUSY: begin
        lfsr_en = 1'b1;
        fresh_n = rnd[RND_W-1:MASK_W];
        cnt_n   = cnt + CNT_W'(1);
        if (cnt == CNT_LAST) begin
          cnt_n       = '0;
          out_data_n  = bus.Y_s0 ^ bus.Y_s1 ^ bus.Y_s2;
          out_valid_n = 1'b1;
          state_n     = ST_DONE;
        end
      end
      ST_DONE: begin
        if (bus.out_ready) begin
          out_valid_n = 1'b0;
          state_n     = ST_IDLE;
          accept      = bus.in_valid;
        end
      end
      default: state_n = ST_IDLE;
    endcase

    // Accept: masks only ever reach X_s1/X_s2; the unmasked nibble is folded into X_s0
    if (accept) begin
      lfsr_en = 1'b1;
      x_s1_n  = rnd[NIB_W-1:0];
      x_s2_n  = rnd[MASK_W-1:NIB_W];
      x_s0_n  = bus.in_data ^ rnd[NIB_W-1:0] ^ rnd[MASK_W-1:NIB_W];
      fresh_n = rnd[RND_W-1:MASK_W];
      cnt_n   = '0;
      state_n = ST_BUSY;
    end
  end

  // State and output registers
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= ST_IDLE;
      cnt       <= '0;
      x_s0      <= '0;
      x_s1      <= '0;
      x_s2      <= '0;
      fresh     <= '0;
      out_valid <= 1'b0;
      out_data  <= '0;
    end else begin
      state     <= state_n;
      cnt       <= cnt_n;
      x_s0      <= x_s0_n;
      x_s1      <= x_s1_n;
      x_s2      <= x_s2_n;
      fresh     <= fresh_n;
      out_valid <= out_valid_n;
      out_data  <= out_data_n;
    end
  end

  assign bus.in_ready  = (state == ST_IDLE) | ((state == ST_DONE) & bus.out_ready);
  assign bus.X_s0      = x_s0;
  assign bus.X_s1      = x_s1;
  assign bus.X_s2      = x_s2;
  assign bus.Fresh     = fresh;
  assign bus.out_valid = out_valid;
  assign bus.out_data  = out_data;

endmodule

// File: doc/sbox_d2_share_driver.md
Name: sbox_d2_share_driver

Overview:
- Driving and collecting end of the 2nd-order (3-share) HPC3 Skinny-64 S-box interface.
- Accepts an unmasked nibble over valid/ready and splits it into 3 Boolean shares using PRNG masks.
- Drives the shares and the 24-bit fresh randomness into the masked S-box, waits out the S-box latency, then recombines the 3 output shares into an unmasked nibble presented over valid/ready.
- Used as the bench/integration front-end for the masked S-box; the top level connects X_s*/Fresh/Y_s* to the S-box instance.

Parameters:
- SBOX_LATENCY, 2, clock cycles from stable X/Fresh to valid Y shares.
- SEED, 64'h0123_4567_89AB_CDEF, LFSR reset value; must be non-zero.

Ports:
- clk  in  1  single clock; all state updates on its rising edge.
- rst  in  1  synchronous, active-high reset.
- in_valid  in  1  unmasked input nibble valid.
- in_ready  out  1  driver can accept a nibble this cycle.
- in_data  in  4  unmasked S-box input.
- seed_load  in  1  load seed into the LFSR (honoured in IDLE only).
- seed  in  64  seed value; all-zero is replaced by SEED.
- X_s0  out  4  share 0 to the S-box.
- X_s1  out  4  share 1 to the S-box.
- X_s2  out  4  share 2 to the S-box.
- Fresh  out  24  gadget randomness to the S-box.
- Y_s0  in  4  output share 0 from the S-box.
- Y_s1  in  4  output share 1 from the S-box.
- Y_s2  in  4  output share 2 from the S-box.
- out_valid  out  1  unmasked result valid.
- out_ready  in  1  consumer accepts the result.
- out_data  out  4  Y_s0^Y_s1^Y_s2.

Behaviour:
- Reset values: state=IDLE, cnt=0, lfsr=SEED, X_s0/X_s1/X_s2=0, Fresh=0, out_valid=0, out_data=0, in_ready=1.
- PRNG: 64-bit Fibonacci LFSR, feedback s[63]^s[62]^s[60]^s[59] shifted into bit 0.
  - Advances 32 steps per enabled cycle.
  - Low 32 bits after advance: [7:0] masks, [31:8] Fresh.
  - Enabled on accept and in every BUSY cycle; otherwise holds.
- FSM:
  - IDLE: in_ready=1. On in_valid: X_s1=m[3:0], X_s2=m[7:4], X_s0=in_data^m[3:0]^m[7:4], Fresh=new[31:8], cnt=0 → BUSY.
  - IDLE, seed_load with no in_valid: lfsr=seed (SEED if seed==0). If both seed_load and in_valid are high, the accept wins and the seed is ignored.
  - BUSY: X_s* held constant; Fresh refreshed every cycle (each HPC3 gadget stage sees new randomness); cnt++.
  - BUSY, when cnt==SBOX_LATENCY-1: out_data <= Y_s0^Y_s1^Y_s2 sampled at that edge, so Y is sampled in the SBOX_LATENCY-th cycle after X is applied → DONE.
  - DONE: out_valid=1; out_data and X_s* stable until out_ready.
  - DONE with out_ready and no in_valid → IDLE.
  - DONE with out_ready and in_valid (in_ready=1 in this case) → accept new nibble, go to BUSY; no idle bubble.
  - DONE with out_ready=0: hold; in_ready=0; in_valid is ignored.
- in_ready = (state==IDLE) | (state==DONE & out_ready).
- Throughput: one nibble per SBOX_LATENCY+1 cycles when out_ready stays high.
- Fresh is only meaningful in BUSY and on the accept edge; its value elsewhere is don't-care but must come from the LFSR (never a constant).
- rst mid-operation: immediately returns to reset values; the in-flight result is dropped and the LFSR reloads SEED.
- Security: unmasked in_data exists only in the input register path; out_data is recombined only after SBOX_LATENCY. No unmasked value ever drives X_s1 or X_s2.

Decomposition:
- Package skinny_mask_pkg holds:
  - NUM_SHARES=3, FRESH_W=24, SBOX_LAT=2.
  - LFSR tap constants and SEED_DEFAULT.
  - Function skinny_sbox(nibble), table {C,6,9,0,1,A,2,B,3,8,5,D,4,E,7,F}, used by the bench and assertions.
  - Enum state_t {IDLE, BUSY, DONE}.
- One sub-module: prng_lfsr64_x32 (en, load, seed → 32-bit output), unrolled 32 steps per cycle.

Test Plan:
- Reset, then in_data=0x0 with out_ready=1 → out_valid exactly 3 cycles after accept, out_data=0xC; X_s0^X_s1^X_s2==0x0 throughout BUSY.
- Sweep in_data 0x0..0xF back-to-back with out_ready=1 → outputs C,6,9,0,1,A,2,B,3,8,5,D,4,E,7,F in order, one every 3 cycles, in_ready high on each DONE cycle.
- in_data=0x4, out_ready=0 for 5 cycles → out_valid stays 1 and out_data=0x1 stable, in_ready=0; raise out_ready → one transfer, then IDLE.
- seed_load with seed=0 in IDLE, then in_data=0xF → LFSR equals SEED_DEFAULT; out_data=0xF; Fresh differs in each BUSY cycle.
- Assert rst during BUSY (cnt=1) → next cycle out_valid=0, in_ready=1, X_s*=0; a following in_data=0x1 → out_data=0x6.
- Two runs with different seeds, same in_data=0x9 → X_s1/X_s2 differ between runs, out_data=0x8 in both.
